// File: rtl/mem_pkg.sv
// Shared types and lane constants for the memory-access stage.
package mem_pkg;

  localparam int DATA_W = 64;
  localparam int BYTE_W = 8;
  localparam int LANES  = DATA_W / BYTE_W;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10,
    MEM_RSVD  = 2'b11
  } memop_t;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } memsize_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10
  } mstate_t;

  function automatic logic [3:0] lane_bytes(memsize_t s);
    return 4'd1 << s;
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed big-endian lane of a load doubleword and zero/sign-extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  offset,
  input  memsize_t    size,
  input  logic        is_signed,
  output logic [63:0] data
);

  logic [63:0] top;
  logic        sign;

  // Shift the addressed lane to the most significant end, then right-justify it.
  always_comb begin
    top  = rdata << {offset, 3'b000};
    sign = is_signed & top[63];
    case (size)
      SZ_BYTE: data = {{56{sign}}, top[63:56]};
      SZ_HALF: data = {{48{sign}}, top[63:48]};
      SZ_WORD: data = {{32{sign}}, top[63:32]};
      default: data = top;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Memory-access pipeline stage: aligned big-endian loads/stores over a variable-latency port,
// feeding the writeback buffer with single-cycle completion pulses.
module memory_stage
  import mem_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int FLAGS_W    = 4,
  parameter int TIMEOUT    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [0:1]            in_memop,
  input  logic [0:1]            in_size,
  input  logic                  in_signed,
  input  logic [0:63]           in_addr,
  input  logic [0:63]           in_store_data,
  input  logic [0:63]           in_alu_result,
  input  logic                  in_regwrite,
  input  logic [REG_ADDR_W-1:0] in_write_addr,
  input  logic                  in_branch,
  input  logic                  in_setflags,
  input  logic [FLAGS_W-1:0]    in_flags,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [0:63]           dmem_addr,
  output logic [0:63]           dmem_wdata,
  output logic [0:7]            dmem_be,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [0:63]           dmem_rdata,
  output logic [0:63]           nwrite_data,
  output logic                  nregwrite,
  output logic [REG_ADDR_W-1:0] nwrite_addr,
  output logic                  nbranch,
  output logic                  nsetflags,
  output logic [FLAGS_W-1:0]    nflags,
  output logic                  mem_fault
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  mstate_t state, state_next;
  logic [WD_W-1:0] wdog;
  logic            wd_expired;

  memop_t          op_q;
  memsize_t        size_q;
  logic            signed_q;
  logic [2:0]      off_q;
  logic [63:0]     addr_q, wdata_q, alu_q;
  logic [7:0]      be_q;
  logic            regwrite_q, branch_q, setflags_q;
  logic [REG_ADDR_W-1:0] waddr_q;
  logic [FLAGS_W-1:0]    flags_q;

  memop_t      in_op;
  memsize_t    in_sz;
  logic [2:0]  in_off;
  logic [3:0]  nbytes, slot;
  logic        misaligned;
  logic [63:0] sdata_mask, lane_wdata;
  logic [7:0]  lane_be;
  logic [63:0] load_data;
  logic        accept, pulse, fault, take_load;

  // Decode the presented op and pre-position store data and byte enables on its lane.
  always_comb begin
    in_op      = memop_t'(in_memop);
    in_sz      = memsize_t'(in_size);
    in_off     = in_addr[61:63];
    nbytes     = lane_bytes(in_sz);
    slot       = 4'(LANES) - {1'b0, in_off} - nbytes;
    case (in_sz)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = in_off[0];
      SZ_WORD: misaligned = |in_off[1:0];
      default: misaligned = |in_off;
    endcase
    sdata_mask = (nbytes == 4'd8) ? '1 : ((64'd1 << {nbytes, 3'b000}) - 64'd1);
    lane_wdata = (in_store_data & sdata_mask) << {slot[2:0], 3'b000};
    lane_be    = ((8'h01 << nbytes) - 8'h01) << slot[2:0];
  end

  assign wd_expired = (TIMEOUT > 0) && (int'(wdog) >= TIMEOUT - 1);

  // Next state plus the one-cycle completion / fault decisions; a response beats the watchdog.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    pulse      = 1'b0;
    fault      = 1'b0;
    take_load  = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          accept = 1'b1;
          if (in_op == MEM_RSVD || (in_op != MEM_NONE && misaligned)) fault = 1'b1;
          else if (in_op == MEM_NONE) pulse = 1'b1;
          else state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (dmem_gnt) begin
          if (op_q == MEM_STORE) begin
            pulse      = 1'b1;
            state_next = S_IDLE;
          end else begin
            state_next = S_WAIT;
          end
        end else if (wd_expired) begin
          fault      = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (dmem_rvalid) begin
          pulse      = 1'b1;
          take_load  = 1'b1;
          state_next = S_IDLE;
        end else if (wd_expired) begin
          fault      = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  load_align u_load_align (
    .rdata     (dmem_rdata),
    .offset    (off_q),
    .size      (size_q),
    .is_signed (signed_q),
    .data      (load_data)
  );

  assign in_ready   = rst && (state == S_IDLE);
  assign dmem_req   = (state == S_REQ);
  assign dmem_we    = (op_q == MEM_STORE);
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;

  // State, watchdog, op capture and writeback outputs; a none-op pulses straight from the inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      wdog        <= '0;
      op_q        <= MEM_NONE;
      size_q      <= SZ_BYTE;
      signed_q    <= 1'b0;
      off_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      alu_q       <= '0;
      be_q        <= '0;
      regwrite_q  <= 1'b0;
      branch_q    <= 1'b0;
      setflags_q  <= 1'b0;
      waddr_q     <= '0;
      flags_q     <= '0;
      nwrite_data <= '0;
      nregwrite   <= 1'b0;
      nwrite_addr <= '0;
      nbranch     <= 1'b0;
      nsetflags   <= 1'b0;
      nflags      <= '0;
      mem_fault   <= 1'b0;
    end else begin
      state     <= state_next;
      wdog      <= (state == S_IDLE || state_next == S_IDLE) ? '0 : wdog + 1'b1;
      mem_fault <= fault;
      if (accept) begin
        op_q       <= in_op;
        size_q     <= in_sz;
        signed_q   <= in_signed;
        off_q      <= in_off;
        addr_q     <= {in_addr[0:60], 3'b000};
        wdata_q    <= lane_wdata;
        be_q       <= lane_be;
        alu_q      <= in_alu_result;
        regwrite_q <= in_regwrite;
        branch_q   <= in_branch;
        setflags_q <= in_setflags;
        waddr_q    <= in_write_addr;
        flags_q    <= in_flags;
      end
      if (pulse && state == S_IDLE) begin
        nwrite_data <= in_alu_result;
        nregwrite   <= in_regwrite;
        nwrite_addr <= in_write_addr;
        nbranch     <= in_branch;
        nsetflags   <= in_setflags;
        nflags      <= in_flags;
      end else if (pulse) begin
        nwrite_data <= take_load ? load_data : alu_q;
        nregwrite   <= regwrite_q;
        nwrite_addr <= waddr_q;
        nbranch     <= branch_q;
        nsetflags   <= setflags_q;
        nflags      <= flags_q;
      end else begin
        nregwrite   <= 1'b0;
        nwrite_addr <= '0;
        nbranch     <= 1'b0;
        nsetflags   <= 1'b0;
        nflags      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Randomized scoreboard bench for memory_stage with a behavioural lane/extension model.
module tb_memory_stage;

  localparam int RA = 5;
  localparam int FW = 4;
  localparam int TO = 8;

  logic          clk, rst;
  logic          in_valid, in_ready;
  logic [0:1]    in_memop, in_size;
  logic          in_signed;
  logic [0:63]   in_addr, in_store_data, in_alu_result;
  logic          in_regwrite, in_branch, in_setflags;
  logic [RA-1:0] in_write_addr;
  logic [FW-1:0] in_flags;
  logic          dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [0:63]   dmem_addr, dmem_wdata, dmem_rdata;
  logic [0:7]    dmem_be;
  logic [0:63]   nwrite_data;
  logic          nregwrite, nbranch, nsetflags, mem_fault;
  logic [RA-1:0] nwrite_addr;
  logic [FW-1:0] nflags;

  typedef struct {
    logic          fault;
    logic          chk_data;
    logic [63:0]   data;
    logic          regwrite;
    logic [RA-1:0] waddr;
    logic          branch;
    logic          setflags;
    logic [FW-1:0] flags;
    int            cycle;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  memory_stage #(.REG_ADDR_W(RA), .FLAGS_W(FW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_memop(in_memop), .in_size(in_size), .in_signed(in_signed),
    .in_addr(in_addr), .in_store_data(in_store_data), .in_alu_result(in_alu_result),
    .in_regwrite(in_regwrite), .in_write_addr(in_write_addr),
    .in_branch(in_branch), .in_setflags(in_setflags), .in_flags(in_flags),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .nwrite_data(nwrite_data), .nregwrite(nregwrite), .nwrite_addr(nwrite_addr),
    .nbranch(nbranch), .nsetflags(nsetflags), .nflags(nflags), .mem_fault(mem_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // Big-endian lane n bytes wide starting at byte o, then zero or sign extended.
  function automatic logic [63:0] modelLoad(input logic [63:0] rd, input int o, input int n, input logic sgn);
    logic [63:0] v, m;
    v = rd >> (8 * (8 - o - n));
    if (n < 8) begin
      m = (64'd1 << (8 * n)) - 64'd1;
      v = v & m;
      if (sgn && v[8*n-1]) v = v | ~m;
    end
    return v;
  endfunction

  task automatic waitReady();
    int i = 0;
    while (!in_ready && i < 20) begin
      @(negedge clk);
      i++;
    end
    checkOutput("in_ready", 64'(in_ready), 64'd1);
  endtask

  // Issue one op, act as the data memory with the given grant / response delays.
  task automatic applyStimulus(input int memop, input int size, input logic sgn,
                               input logic [63:0] addr, input logic [63:0] sdata,
                               input logic [63:0] alu, input logic [63:0] rd,
                               input int gw, input int rw);
    exp_t e;
    int n, o, acc;
    logic [63:0] exp_wdata;
    logic [0:7]  exp_be;
    logic [RA-1:0] wa;
    logic br, sf;
    logic [FW-1:0] fl;
    waitReady();
    wa = RA'($urandom());
    br = 1'($urandom());
    sf = 1'($urandom());
    fl = FW'($urandom());
    n  = 1 << size;
    o  = int'(addr[2:0]);
    in_valid = 1'b1;
    in_memop = 2'(memop);
    in_size  = 2'(size);
    in_signed = sgn;
    in_addr = addr;
    in_store_data = sdata;
    in_alu_result = alu;
    in_regwrite = 1'b1;
    in_write_addr = wa;
    in_branch = br;
    in_setflags = sf;
    in_flags = fl;
    acc = cyc + 1;
    e.fault    = (memop == 3) || (memop != 0 && (o % n) != 0);
    e.chk_data = !e.fault;
    e.regwrite = !e.fault;
    e.waddr    = e.fault ? '0 : wa;
    e.branch   = e.fault ? 1'b0 : br;
    e.setflags = e.fault ? 1'b0 : sf;
    e.flags    = e.fault ? '0 : fl;
    e.data     = (memop == 1) ? modelLoad(rd, o, n, sgn) : alu;
    if (e.fault || memop == 0) e.cycle = acc;
    else if (memop == 2) e.cycle = acc + 1 + gw;
    else e.cycle = acc + 2 + gw + rw;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    in_addr = rand64();
    in_store_data = rand64();
    in_alu_result = rand64();
    in_regwrite = 1'b0;
    in_memop = 2'($urandom());
    in_size = 2'($urandom());
    if (e.fault) checkOutput("no_req_on_fault", 64'(dmem_req), 64'd0);
    if (e.fault || memop == 0) return;
    exp_wdata = (n == 8) ? sdata : ((sdata & ((64'd1 << (8 * n)) - 64'd1)) << (8 * (8 - o - n)));
    exp_be = '0;
    for (int k = o; k < o + n; k++) exp_be[k] = 1'b1;
    checkOutput("req_asserted", 64'(dmem_req), 64'd1);
    checkOutput("dmem_addr", 64'(dmem_addr), addr & ~64'h7);
    checkOutput("dmem_we", 64'(dmem_we), 64'(memop == 2));
    if (memop == 2) begin
      checkOutput("dmem_wdata", 64'(dmem_wdata), exp_wdata);
      checkOutput("dmem_be", 64'(dmem_be), 64'(exp_be));
    end
    for (int i = 0; i < gw; i++) begin
      dmem_rvalid = 1'($urandom());
      dmem_rdata = rand64();
      @(negedge clk);
      checkOutput("req_held", 64'(dmem_req), 64'd1);
    end
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0;
    checkOutput("req_dropped", 64'(dmem_req), 64'd0);
    if (memop == 1) begin
      repeat (rw) @(negedge clk);
      dmem_rvalid = 1'b1;
      dmem_rdata = rd;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      dmem_rdata = rand64();
    end
  endtask

  // Monitor: any visible writeback/fault activity must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (nregwrite || nbranch || nsetflags || mem_fault || (nflags != '0) || (nwrite_addr != '0)) begin
        if (sb.size() == 0) begin
          checkOutput("stray_pulse", 64'({nregwrite, nbranch, nsetflags, mem_fault, nflags, nwrite_addr}), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("pulse_cycle", 64'(cyc), 64'(mon_e.cycle));
          checkOutput("mem_fault", 64'(mem_fault), 64'(mon_e.fault));
          checkOutput("nregwrite", 64'(nregwrite), 64'(mon_e.regwrite));
          checkOutput("nwrite_addr", 64'(nwrite_addr), 64'(mon_e.waddr));
          checkOutput("nbranch", 64'(nbranch), 64'(mon_e.branch));
          checkOutput("nsetflags", 64'(nsetflags), 64'(mon_e.setflags));
          checkOutput("nflags", 64'(nflags), 64'(mon_e.flags));
          if (mon_e.chk_data) checkOutput("nwrite_data", 64'(nwrite_data), mon_e.data);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    int acc, mop, sz, n;
    logic [63:0] a;
    rst = 1'b1;
    in_valid = 1'b0; in_memop = '0; in_size = '0; in_signed = 1'b0;
    in_addr = '0; in_store_data = '0; in_alu_result = '0;
    in_regwrite = 1'b0; in_write_addr = '0; in_branch = 1'b0; in_setflags = 1'b0; in_flags = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    #1 rst = 1'b0;
    #2;
    checkOutput("reset_req", 64'(dmem_req), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
    checkOutput("reset_nregwrite", 64'(nregwrite), 64'd0);
    checkOutput("reset_fault", 64'(mem_fault), 64'd0);
    checkOutput("reset_nwrite_data", 64'(nwrite_data), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Back-to-back non-memory ops.
    applyStimulus(0, 3, 0, 64'h10, 64'h0, 64'h1111_1111_1111_1111, 64'h0, 0, 0);
    checkOutput("t1_first", 64'(nwrite_data), 64'h1111_1111_1111_1111);
    applyStimulus(0, 1, 0, 64'h11, 64'h0, 64'h2222_2222_2222_2222, 64'h0, 0, 0);
    checkOutput("t1_second", 64'(nwrite_data), 64'h2222_2222_2222_2222);

    // Signed and unsigned byte load from offset 3.
    applyStimulus(1, 0, 1, 64'h1003, 64'h0, 64'h0, 64'h0000_0080_0000_0000, 0, 0);
    checkOutput("t2_signed", 64'(nwrite_data), 64'hFFFF_FFFF_FFFF_FF80);
    applyStimulus(1, 0, 0, 64'h1003, 64'h0, 64'h0, 64'h0000_0080_0000_0000, 1, 2);
    checkOutput("t2_unsigned", 64'(nwrite_data), 64'h80);

    // Half store at offset 6 with a delayed grant, then a misaligned word load.
    applyStimulus(2, 1, 0, 64'h2006, 64'h1234_5678_9ABC_BEEF, 64'h55, 64'h0, 2, 0);
    applyStimulus(1, 2, 0, 64'h3002, 64'h0, 64'h0, rand64(), 0, 0);

    // Watchdog: granted load with no response.
    waitReady();
    in_valid = 1'b1; in_memop = 2'b01; in_size = 2'b10; in_addr = 64'h4000;
    in_regwrite = 1'b1; in_write_addr = 5'd7;
    acc = cyc + 1;
    sb.push_back('{fault: 1'b1, chk_data: 1'b0, data: 64'h0, regwrite: 1'b0, waddr: '0,
                   branch: 1'b0, setflags: 1'b0, flags: '0, cycle: acc + 8});
    @(negedge clk);
    in_valid = 1'b0; in_regwrite = 1'b0; in_write_addr = '0;
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    repeat (7) @(negedge clk);
    checkOutput("wd_req_dropped", 64'(dmem_req), 64'd0);
    checkOutput("wd_idle", 64'(in_ready), 64'd1);
    dmem_rvalid = 1'b1; dmem_rdata = rand64();
    @(negedge clk);
    dmem_rvalid = 1'b0; dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while waiting for load data.
    waitReady();
    in_valid = 1'b1; in_memop = 2'b01; in_size = 2'b11; in_addr = 64'h5000;
    in_regwrite = 1'b1; in_write_addr = 5'd9;
    @(negedge clk);
    in_valid = 1'b0; in_regwrite = 1'b0; in_write_addr = '0;
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_mid_req", 64'(dmem_req), 64'd0);
    checkOutput("rst_mid_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_mid_nregwrite", 64'(nregwrite), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = rand64();
    @(negedge clk);
    dmem_rvalid = 1'b0;
    checkOutput("rst_after_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_after_data", 64'(nwrite_data), 64'd0);
    repeat (2) @(negedge clk);

    // Randomized traffic.
    for (int t = 0; t < 80; t++) begin
      n = $urandom_range(0, 9);
      mop = (n < 3) ? 0 : (n < 6) ? 1 : (n < 9) ? 2 : 3;
      sz = $urandom_range(0, 3);
      a = rand64();
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      applyStimulus(mop, sz, 1'($urandom()), a, rand64(), rand64(), rand64(),
                    $urandom_range(0, 2), $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) begin
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = rand64();
        @(negedge clk);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      end
    end

    repeat (4) @(negedge clk);
    checkOutput("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
